switch_debounce: RTL

Input-side companion to the counter-driven LED blinker on the GoBoard (iCE40): reads a mechanical push-button or switch pin and turns it into a clean level. A 2-flop synchronizer is followed by a stability counter built on the same saturating-count idea as the blink counter. The block outputs a debounced level, single-cycle rise/fall strobes and an optional press counter. It sits between a board input pin and any user logic in `main`.

---
 rtl/switch_debounce.sv | 88 ++++++++
 1 files changed

// File: rtl/switch_debounce.sv
// switch_debounce: 2-flop synchronizer plus stability counter turning a bouncy
// switch pin into a clean level with single-cycle rise/fall strobes.
// Optional press counter on COUNT when SWITCH_DEBOUNCE_COUNT_EN is defined;
// otherwise COUNT is tied to 8'h00.
module switch_debounce #(
    parameter int unsigned CNT_WIDTH = 18,
    parameter int unsigned LIMIT     = 250000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       I,
    output logic       O,
    output logic       RISE,
    output logic       FALL,
    output logic [7:0] COUNT
);

    localparam logic [CNT_WIDTH-1:0] TERM = CNT_WIDTH'(LIMIT - 1);

    logic                 s1_q;
    logic                 s2_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;
    logic                 o_q;
    logic                 o_d;
    logic                 rise_q;
    logic                 rise_d;
    logic                 fall_q;
    logic                 fall_d;

    // Next-state: clear on agreement, accept after LIMIT differing samples
    always_comb begin
        o_d    = o_q;
        cnt_d  = '0;
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (s2_q != o_q) begin
            if (cnt_q == TERM) begin
                o_d    = s2_q;
                rise_d = s2_q;
                fall_d = ~s2_q;
            end else begin
                cnt_d = cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    // Synchronizer, stability counter and registered outputs
    always_ff @(posedge CLK) begin
        if (RESET) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            cnt_q  <= '0;
            o_q    <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            s1_q   <= I;
            s2_q   <= s1_q;
            cnt_q  <= cnt_d;
            o_q    <= o_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign O    = o_q;
    assign RISE = rise_q;
    assign FALL = fall_q;

`ifdef SWITCH_DEBOUNCE_COUNT_EN
    logic [7:0] count_q;

    // Press counter advances on the same edge that raises RISE
    always_ff @(posedge CLK) begin
        if (RESET) begin
            count_q <= 8'h00;
        end else if (rise_d) begin
            count_q <= count_q + 8'd1;
        end
    end

    assign COUNT = count_q;
`else
    assign COUNT = 8'h00;
`endif

endmodule
